rr_encoder_arbiter: RTL
=======================

Name: rr_encoder_arbiter

Overview:
- 16-requester round-robin arbiter built around a 16-to-4 priority-encoding datapath.
- Shares one downstream resource among 16 requesters.
- Outputs a one-hot grant plus the 4-bit encoded grant index.
- Sits between request sources and the shared resource; the index drives the resource's select mux.

Parameters:
- N, 16, number of requesters (must be a power of 2).
- IDX_W, 4, encoded index width, equal to log2(N).
- HOLD_MAX, 8, maximum grant tenure in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- req  input  N  request vector; bit k = requester k wants the resource.
- done  input  1  current grantee releases the resource this cycle.
- gnt  output  N  one-hot grant; all zero when idle.
- gnt_idx  output  IDX_W  binary index of the granted requester; 0 when idle.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse on forced release; tied 0 when ARB_TIMEOUT_EN is not defined.

Behaviour:
- Reset (async assert, any time): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, rr pointer ptr=0. A reset mid-grant drops the grant immediately and does not wait for a clock edge.
- All outputs are registered. No combinational path from req/done to outputs.
- States:
  - IDLE: if req!=0, select a winner; on the next edge go to GRANT with gnt/gnt_idx/gnt_valid set. If req==0, stay in IDLE.
  - GRANT: hold gnt stable. A release occurs when done=1, or when req[gnt_idx]=0 (requester withdraws).
- On a release cycle, arbitrate among req with the current grantee's bit masked out:
  - If another request exists, load the new grant on the next edge (zero-bubble back-to-back).
  - Otherwise go to IDLE with outputs cleared.
- Winner selection: the first set bit of req searching upward from ptr, wrapping 15->0. Example: ptr=14, req=0x8001 -> winner 15; ptr=0, same req -> winner 0.
- On every new grant, ptr <= winner+1 modulo N (15 -> 0).
- Simultaneous done and new requests: handled by the same-cycle re-arbitration above. The released requester is excluded for that one arbitration even if its req stays high; it is eligible again afterwards.
- done while in IDLE is ignored.
- Requests arriving while in GRANT wait; there is no pre-emption.
- gnt is always one-hot or zero; gnt_idx always equals the encoded gnt.
- Latency: req asserted at edge t (IDLE) -> gnt visible after edge t+1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A tenure counter (width ceil(log2(HOLD_MAX+1))) clears on each new grant and increments every GRANT cycle.
  - When it reaches HOLD_MAX-1 without a release, that cycle is treated as a release.
  - timeout pulses high for 1 cycle, aligned with the new grant (or the IDLE entry).
  - Counter resets to 0.
- Not defined: no counter; grant is held indefinitely until done or req withdrawal; timeout constant 0.

Decomposition:
- Package arb_pkg:
  - localparams N=16, IDX_W=4.
  - State enum {IDLE, GRANT}.
  - Function onehot_to_idx (16-to-4 encode).
- One sub-module, rr_priority_encoder: combinational. Inputs req, ptr, mask_idx/mask_en. Outputs any, win_idx, win_onehot.
- The arbiter instantiates it once; FSM, ptr and optional counter stay in the top.

Test Plan:
- Reset: rst=1 mid-grant (gnt=0x0010) -> gnt=0, gnt_idx=0, gnt_valid=0 asynchronously. After release with req=0x0001 -> gnt=0x0001, idx=0 one cycle later.
- Single-bit sweep: req=1<<k for k=0..15, each followed by a done pulse -> gnt_idx=k, gnt=1<<k every time.
- Fairness: req=0xFFFF held, done pulsed each cycle -> gnt_idx sequence 0,1,2,...,15,0 with no bubble cycles.
- Wrap and mask: grant idx 14 held; req=0xC001; done -> next grant 15; done -> 0; done -> 14.
- Withdrawal and idle: grant idx 3; drop req[3] with req=0 -> IDLE next cycle, gnt_valid=0. done asserted in IDLE -> no change.
- ARB_TIMEOUT_EN (HOLD_MAX=8): req=0x0003, done never asserted -> grant 0 for 8 cycles; timeout pulse; grant 1 for 8 cycles; grant 0 ...

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-requester round-robin arbiter.
// Provides N, IDX_W, HOLD_MAX, the FSM state enum and a one-hot to binary encoder.
// No ports; imported by rr_priority_encoder and rr_encoder_arbiter.
package arb_pkg;

   localparam int N        = 16;
   localparam int IDX_W    = 4;
   // Maximum grant tenure; only consulted when ARB_TIMEOUT_EN is defined.
   localparam int HOLD_MAX = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // OR-reduction encoder: exact for one-hot input, returns 0 for all-zero.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) r = r | IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational rotating priority encoder: first set bit of req searching up from ptr, wrapping.
// Ports: req (N), ptr (IDX_W) start position, mask_idx/mask_en exclude one requester;
//        any = some candidate exists, win_idx/win_onehot = selected winner (0 when none).
module rr_priority_encoder
   import arb_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [IDX_W-1:0] mask_idx,
   input  logic             mask_en,
   output logic             any,
   output logic [IDX_W-1:0] win_idx,
   output logic [N-1:0]     win_onehot
);

   logic [N-1:0]     cand;
   logic [IDX_W-1:0] probe;

   always_comb begin
      cand  = req;
      any   = 1'b0;
      win_idx = '0;
      probe = '0;
      if (mask_en) cand[mask_idx] = 1'b0;
      // probe wraps naturally at IDX_W bits because N is a power of two
      for (int i = 0; i < N; i++) begin
         probe = ptr + IDX_W'(i);
         if (!any && cand[probe]) begin
            any     = 1'b1;
            win_idx = probe;
         end
      end
      win_onehot = any ? (N'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// 16-requester round-robin arbiter with registered one-hot grant and encoded index.
// Ports: clk, rst (async, active-high), req[N], done -> gnt[N], gnt_idx[IDX_W], gnt_valid, timeout.
// Optional macro ARB_TIMEOUT_EN: forces a release after HOLD_MAX grant cycles and pulses timeout.
module rr_encoder_arbiter
   import arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [N-1:0]     gnt_nxt;
   logic [IDX_W-1:0] gnt_idx_nxt;
   logic             gnt_valid_nxt;
   logic             timeout_nxt;
   logic             new_grant;

   logic             any;
   logic [IDX_W-1:0] win_idx;
   logic [N-1:0]     win_onehot;
   logic             rel_normal;
   logic             forced;
   logic             rel;

   // While granted, the current holder is excluded so a release re-arbitrates among others.
   rr_priority_encoder u_enc (
      .req        (req),
      .ptr        (ptr),
      .mask_idx   (gnt_idx),
      .mask_en    (state == GRANT),
      .any        (any),
      .win_idx    (win_idx),
      .win_onehot (win_onehot)
   );

   assign rel_normal = (state == GRANT) && (done || !req[gnt_idx]);

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(HOLD_MAX + 1);
   logic [CNT_W-1:0] tenure;

   // Cycle HOLD_MAX-1 of a tenure with no natural release counts as a release.
   assign forced = (state == GRANT) && !rel_normal && (tenure == CNT_W'(HOLD_MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tenure <= '0;
      end else if (new_grant || state_nxt != GRANT) begin
         tenure <= '0;
      end else begin
         tenure <= tenure + 1'b1;
      end
   end
`else
   assign forced = 1'b0;
`endif

   assign rel = rel_normal || forced;

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      gnt_nxt       = gnt;
      gnt_idx_nxt   = gnt_idx;
      gnt_valid_nxt = gnt_valid;
      timeout_nxt   = 1'b0;
      new_grant     = 1'b0;
      case (state)
         IDLE: begin
            if (any) new_grant = 1'b1;
         end
         GRANT: begin
            timeout_nxt = forced;
            if (rel) begin
               if (any) begin
                  new_grant = 1'b1;
               end else begin
                  state_nxt     = IDLE;
                  gnt_nxt       = '0;
                  gnt_idx_nxt   = '0;
                  gnt_valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            state_nxt     = IDLE;
            gnt_nxt       = '0;
            gnt_idx_nxt   = '0;
            gnt_valid_nxt = 1'b0;
         end
      endcase
      if (new_grant) begin
         state_nxt     = GRANT;
         gnt_nxt       = win_onehot;
         gnt_idx_nxt   = onehot_to_idx(win_onehot);
         gnt_valid_nxt = 1'b1;
         ptr_nxt       = win_idx + 1'b1;  // wraps 15 -> 0
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         gnt       <= gnt_nxt;
         gnt_idx   <= gnt_idx_nxt;
         gnt_valid <= gnt_valid_nxt;
         timeout   <= timeout_nxt;
      end
   end

endmodule
